uart_rx: RTL and testbench

UART receiver: the receive end of the serial link driven by our transmit block. It recovers 8N1 frames from the asynchronous rx_pin using a 16x oversampling clock enable. Each received byte is presented on a valid/ready output port to the consuming logic, which is typically a command decoder or buffer for the SDRAM controller.

---
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - 8N1 UART receiver with 16x (OVERSAMPLE) oversampling.
//
// Recovers frames from the asynchronous rx_pin and hands each good byte to
// the consumer over a valid/ready port. Every bit is decided by a 3-sample
// majority vote around mid-bit. The stop bit is decided at mid-bit and the
// FSM returns to IDLE straight away, so back-to-back frames are not missed.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   baud_clk   one-clk-wide enable at OVERSAMPLE x baud rate
//   rx_pin     serial input, asynchronous, idle high
//   data_out   last good received byte
//   rx_valid   data_out holds an unconsumed byte
//   rx_ready   consumer accepts the byte when rx_valid && rx_ready
//   frame_err  one-clk pulse: stop bit sampled low (byte discarded)
//   overrun    one-clk pulse: an unconsumed byte was overwritten
//   rx_busy    FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_clk,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] MID       = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_nxt;
    logic                   sync1, sync2, rxs;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [1:0]             smp;
    logic [DATA_BITS-1:0]   shreg;
    logic                   smp_tick, decide, bit_end, maj;
    logic                   byte_done, stop_bad;

    // Two-flop synchronizer; both flops reset high so the line looks idle
    // coming out of reset and no false start is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_pin;
            sync2 <= sync1;
        end
    end

    assign rxs = sync2;

    // Sampling points: the first two votes are stored, the third is the live
    // rxs at the decision tick.
    assign smp_tick = baud_clk && (tick_cnt == MID - TW'(1) || tick_cnt == MID);
    assign decide   = baud_clk && (state != IDLE) && (tick_cnt == MID + TW'(1));
    assign bit_end  = baud_clk && (tick_cnt == LAST_TICK);
    assign maj      = (smp[1] & smp[0]) | (smp[1] & rxs) | (smp[0] & rxs);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (baud_clk && !rxs) state_nxt = START;
            START: begin
                if (decide && maj)  state_nxt = IDLE;   // false start
                else if (bit_end)   state_nxt = DATA;
            end
            DATA:  if (bit_end && bit_cnt == LAST_BIT) state_nxt = STOP;
            STOP:  if (decide) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / event decode
    always_comb begin
        rx_busy   = (state != IDLE);
        byte_done = (state == STOP) && decide && maj;
        stop_bad  = (state == STOP) && decide && !maj;
    end

    // Bit timing, vote samples and shift register; only advance on ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            smp      <= 2'b11;
            shreg    <= '0;
        end else if (baud_clk) begin
            if (state == IDLE || tick_cnt == LAST_TICK) tick_cnt <= '0;
            else                                        tick_cnt <= tick_cnt + TW'(1);

            if (state != DATA)  bit_cnt <= '0;
            else if (bit_end)   bit_cnt <= bit_cnt + BW'(1);

            if (smp_tick && state != IDLE) smp <= {smp[0], rxs};

            // LSB arrives first, so shift in at the MSB end.
            if (state == DATA && decide) begin
                if (DATA_BITS > 1) shreg <= {maj, shreg[DATA_BITS-1:1]};
                else               shreg <= DATA_BITS'(maj);
            end
        end
    end

    // Consumer port and status pulses; these run on every clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            // An accept on the same edge as a new byte is not an overrun.
            overrun   <= byte_done && rx_valid && !rx_ready;
            if (byte_done) begin
                data_out <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx - directed bench for uart_rx (OVERSAMPLE=16, DATA_BITS=8).
// baud_clk is one clk in four, so one bit time is 64 clk. Frames are started
// just after the edge where the divider becomes 1, which makes the stop-bit
// decision land on edge 620 counted from the start of the frame.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT_CLK = 64;
    localparam int LAT     = 620;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_clk;
    logic       rx_pin = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    logic [1:0] div = 2'd0;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         fe_cnt, ov_cnt, vld_cyc;
    logic [7:0] cap;
    int         lat;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_clk  (baud_clk),
        .rx_pin    (rx_pin),
        .data_out  (data_out),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) div <= div + 2'd1;
    assign baud_clk = (div == 2'd0);

    // Observation counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
        if (rx_valid) begin
            vld_cyc++;
            cap = data_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        fe_cnt  = 0;
        ov_cnt  = 0;
        vld_cyc = 0;
        cap     = 8'h00;
    endtask

    task automatic align();
        do begin
            @(posedge clk);
            #1;
        end while (div != 2'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting now (just after an edge); returns 10 bits later.
    task automatic send_byte(input logic [7:0] d, input logic stp);
        rx_pin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CLK) @(posedge clk);
            #1 rx_pin = d[i];
        end
        repeat (BIT_CLK) @(posedge clk);
        #1 rx_pin = stp;
        repeat (BIT_CLK) @(posedge clk);
        #1 rx_pin = 1'b1;
    endtask

    initial begin
        clr();
        #23;
        chk("rst_data",  32'(data_out),  32'h0);
        chk("rst_valid", 32'(rx_valid),  32'h0);
        chk("rst_busy",  32'(rx_busy),   32'h0);
        chk("rst_ferr",  32'(frame_err), 32'h0);
        chk("rst_ovr",   32'(overrun),   32'h0);
        rst_n = 1'b1;
        idle(20);

        // Clean 0xA5, consumer always ready; measure landing edge.
        rx_ready = 1'b1;
        clr();
        align();
        lat = 0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                while (!rx_valid && lat < 2000) begin
                    @(posedge clk);
                    lat++;
                    #1;
                end
            end
        join
        idle(2 * BIT_CLK);
        chk("a5_latency", 32'(lat),     32'(LAT));
        chk("a5_cap",     32'(cap),     32'hA5);
        chk("a5_data",    32'(data_out), 32'hA5);
        chk("a5_vld_cyc", 32'(vld_cyc), 32'd1);
        chk("a5_ferr",    32'(fe_cnt),  32'd0);
        chk("a5_ovr",     32'(ov_cnt),  32'd0);
        chk("a5_busy",    32'(rx_busy), 32'd0);

        // Short low glitch: START must abort.
        clr();
        align();
        rx_pin = 1'b0;
        idle(16);
        rx_pin = 1'b1;
        idle(16);
        chk("glitch_busy_mid", 32'(rx_busy), 32'd1);
        idle(64);
        chk("glitch_busy_end", 32'(rx_busy), 32'd0);
        chk("glitch_vld",      32'(vld_cyc), 32'd0);

        // Stop bit low: frame error, previous byte kept.
        clr();
        align();
        send_byte(8'h5A, 1'b0);
        idle(2 * BIT_CLK);
        chk("ferr_cnt",  32'(fe_cnt),   32'd1);
        chk("ferr_vld",  32'(vld_cyc),  32'd0);
        chk("ferr_data", 32'(data_out), 32'hA5);
        chk("ferr_busy", 32'(rx_busy),  32'd0);

        // Break: line low for 160 ticks gives exactly one frame error.
        clr();
        align();
        rx_pin = 1'b0;
        idle(640 - 1);
        rx_pin = 1'b1;
        idle(2 * BIT_CLK);
        chk("brk_ferr", 32'(fe_cnt),   32'd1);
        chk("brk_vld",  32'(vld_cyc),  32'd0);
        chk("brk_data", 32'(data_out), 32'hA5);
        chk("brk_busy", 32'(rx_busy),  32'd0);

        // Back-to-back with consumer stalled: overrun.
        rx_ready = 1'b0;
        clr();
        align();
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        idle(BIT_CLK);
        chk("ovr_data",  32'(data_out), 32'hC3);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        chk("ovr_cnt",   32'(ov_cnt),   32'd1);
        chk("ovr_ferr",  32'(fe_cnt),   32'd0);
        rx_ready = 1'b1;
        idle(1);
        chk("ovr_accept", 32'(rx_valid), 32'd0);

        // Accept coincides with the next byte landing.
        rx_ready = 1'b0;
        align();
        send_byte(8'h11, 1'b1);
        idle(BIT_CLK);
        chk("coin_first", 32'(data_out), 32'h11);
        clr();
        align();
        fork
            send_byte(8'h22, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        chk("coin_valid", 32'(rx_valid), 32'd1);
        chk("coin_data",  32'(data_out), 32'h22);
        chk("coin_ovr",   32'(ov_cnt),   32'd0);

        // Reset in DATA bit 3 of 0xFF, then a clean 0x81.
        idle(BIT_CLK);
        align();
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (4 * BIT_CLK + 30) @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("mrst_data",  32'(data_out),  32'h0);
                chk("mrst_valid", 32'(rx_valid),  32'h0);
                chk("mrst_busy",  32'(rx_busy),   32'h0);
                chk("mrst_flags", 32'({frame_err, overrun}), 32'h0);
                repeat (5) @(posedge clk);
                #1 rst_n = 1'b1;
                clr();
            end
        join
        idle(2 * BIT_CLK);
        chk("mrst_no_byte", 32'(vld_cyc), 32'd0);
        chk("mrst_no_ferr", 32'(fe_cnt),  32'd0);
        rx_ready = 1'b1;
        clr();
        align();
        send_byte(8'h81, 1'b1);
        idle(BIT_CLK);
        chk("x81_cap",     32'(cap),      32'h81);
        chk("x81_data",    32'(data_out), 32'h81);
        chk("x81_vld_cyc", 32'(vld_cyc),  32'd1);
        chk("x81_ferr",    32'(fe_cnt),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
